// File: rtl/rr_mux_scheduler.sv
// Round-robin scheduler in front of a shared N:1 selector datapath.
// One requester is granted per capture. Its data and index are held in a
// one-entry output register that is drained with a valid/ready handshake.
// A capture can overlap a transfer, so the block sustains one word per cycle.
module rr_mux_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_LEN  = 2,
    parameter int DATA_LEN = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data,
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_LEN-1:0]          out_data,
    output logic [SEL_LEN-1:0]           out_sel,
    output logic                         busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [SEL_LEN-1:0]  ptr;
    logic [SEL_LEN-1:0]  win_idx;
    logic [SEL_LEN-1:0]  scan_idx;
    logic                win_found;
    logic                cap;

    // Rotating priority scan: the first set request at or after ptr wins.
    // The index wraps for free because NUM_REQ is a power of two.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = ptr + SEL_LEN'(k);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next state and grant. The register can be refilled when it is empty
    // or being drained. The grant is suppressed while reset is asserted.
    always_comb begin
        cap       = (state == IDLE) || out_ready;
        state_nxt = state;
        gnt       = '0;
        if (!rst && cap) begin
            if (win_found) begin
                gnt[win_idx] = 1'b1;
                state_nxt    = HOLD;
            end else begin
                state_nxt    = IDLE;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output word, mux key and priority pointer. All update only on a
    // successful capture. The winner gets the lowest priority next time.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            out_data <= '0;
            out_sel  <= '0;
        end else if (cap && win_found) begin
            out_data <= req_data[win_idx*DATA_LEN +: DATA_LEN];
            out_sel  <= win_idx;
            ptr      <= win_idx + 1'b1;
        end
    end

    assign out_valid = (state == HOLD);
    assign busy      = out_valid;

endmodule
